// File: rtl/ram_stream_reader.sv
// Read master for a 1-cycle-latency dual-port RAM.
// Streams len words from base_addr out through a 4-entry valid/ready FIFO.
module ram_stream_reader #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] ram_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_A  = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW:0]      issued_q;
    logic [AW:0]      len_q;
    logic [AW:0]      beat_q;
    logic [AW:0]      len_sat;
    logic             p1_q, p2_q;
    logic [WIDTH-1:0] mem [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       cnt;
    logic [3:0]       occ;
    logic             pop, credit, issue, load, done_d;
    logic [AW-1:0]    rd_next;

    assign pop     = m_valid & m_ready;
    // Slots already committed: stored words plus reads still in the RAM pipe.
    assign occ     = {1'b0, cnt} + {3'b0, p1_q} + {3'b0, p2_q} - {3'b0, pop};
    assign credit  = occ < 4'd4;
    assign len_sat = (len > DEPTH_L) ? DEPTH_L : len;
    assign rd_next = (rd_addr == LAST_A) ? '0 : rd_addr + 1'b1;

    assign busy    = (state_q != IDLE);
    assign m_valid = (cnt != 3'd0);
    assign m_data  = mem[rd_ptr];
    assign m_last  = m_valid && (beat_q == len_q - 1'b1);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        load    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = READ;
                        load    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issued_q == len_q) state_d = DRAIN;
                else if (credit)       issue   = 1'b1;
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            done     <= 1'b0;
            rd_addr  <= '0;
            issued_q <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            p1_q    <= load | issue;
            p2_q    <= p1_q;
            if (load) begin
                rd_addr  <= base_addr;
                issued_q <= (AW+1)'(1);
                len_q    <= len_sat;
            end else if (issue) begin
                rd_addr  <= rd_next;
                issued_q <= issued_q + 1'b1;
            end
            if (load)     beat_q <= '0;
            else if (pop) beat_q <= beat_q + 1'b1;
            if (p2_q) begin
                mem[wr_ptr] <= ram_dout;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {2'b0, p2_q} - {2'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle registered RAM model
// preloaded with mem[i] = i.
module tb_ram_stream_reader;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      len;
    logic             busy;
    logic             done;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] ram_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    logic [WIDTH-1:0] ram [DEPTH];

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] cap [$];
    int               last_idx;
    logic             got_done;

    ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .len(len), .busy(busy), .done(done), .rd_addr(rd_addr),
        .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i);
    always @(posedge clk) ram_dout <= ram[rd_addr];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs the handshake until done or the cycle budget expires, logging beats.
    task automatic drain(input logic [7:0] pat, input int maxc);
        cap.delete();
        last_idx = -1;
        got_done = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            m_ready = pat[c % 8];
            if (m_valid && m_ready) begin
                if (m_last) last_idx = cap.size();
                cap.push_back(m_data);
            end
            cyc();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
        cyc(); cyc();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags busy=%b done=%b valid=%b exp 0 0 0", busy, done, m_valid);
        end
        vectors++;
        if (m_last !== 1'b0 || rd_addr !== 3'd0 || m_data !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_data last=%b addr=%0d data=%0d exp 0 0 0", m_last, rd_addr, m_data);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        base_addr = 3'd2; len = 4'd4; m_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || m_valid !== 1'b0 || rd_addr !== 3'd2) begin
            miscompares++;
            $display("FAIL basic_issue0 busy=%b valid=%b addr=%0d exp 1 0 2", busy, m_valid, rd_addr);
        end
        cyc();
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency valid=%b exp 0", m_valid);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            vectors++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(2 + k) || m_last !== (k == 3)) begin
                miscompares++;
                $display("FAIL basic_beat%0d valid=%b data=%0d last=%b exp 1 %0d %0d",
                         k, m_valid, m_data, m_last, 2 + k, k == 3);
            end
        end
        cyc();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done done=%b busy=%b valid=%b exp 1 0 0", done, busy, m_valid);
        end
        cyc();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse done=%b exp 0", done);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea [4];
        ea[0] = 3'd6; ea[1] = 3'd7; ea[2] = 3'd0; ea[3] = 3'd1;
        base_addr = 3'd6; len = 4'd4; m_ready = 1'b1; start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            start = 1'b0;
            if (k < 4) begin
                vectors++;
                if (rd_addr !== ea[k]) begin
                    miscompares++;
                    $display("FAIL wrap_addr%0d got=%0d exp=%0d", k, rd_addr, ea[k]);
                end
            end
            if (k >= 2 && k <= 5) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== WIDTH'(ea[k-2])) begin
                    miscompares++;
                    $display("FAIL wrap_data%0d valid=%b data=%0d exp 1 %0d", k - 2, m_valid, m_data, ea[k-2]);
                end
            end
            if (k == 6) begin
                vectors++;
                if (done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wrap_done got=%b exp=1", done);
                end
            end
        end
        cyc();
    endtask

    task automatic test_stall();
        logic [7:0]       pat = 8'b0110_1001;
        int               exp_d = 2;
        int               beats = 0;
        int               errs  = 0;
        logic             pv = 1'b0, pr = 1'b0, fin = 1'b0;
        logic [WIDTH-1:0] pd = '0;
        base_addr = 3'd2; len = 4'd4; start = 1'b1;
        for (int c = 0; c < 40 && !fin; c++) begin
            m_ready = pat[c % 8];
            if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd)) begin
                errs++;
                $display("FAIL stall_hold cyc=%0d valid=%b data=%0d exp 1 %0d", c, m_valid, m_data, pd);
            end
            if (m_valid) begin
                if (m_data !== WIDTH'(exp_d) || m_last !== (exp_d == 5)) begin
                    errs++;
                    $display("FAIL stall_order data=%0d last=%b exp %0d %0d", m_data, m_last, exp_d, exp_d == 5);
                end
                if (m_ready) begin
                    exp_d++;
                    beats++;
                end
            end
            pv = m_valid; pr = m_ready; pd = m_data;
            cyc();
            start = 1'b0;
            if (done) fin = 1'b1;
        end
        vectors++;
        if (errs != 0) miscompares++;
        vectors++;
        if (beats != 4 || fin !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_count beats=%0d done=%b exp 4 1", beats, fin);
        end
        cyc();
    endtask

    task automatic test_credit();
        base_addr = 3'd0; len = 4'd8; m_ready = 1'b0; start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            start = 1'b0;
            if (k >= 3) begin
                vectors++;
                if (rd_addr !== 3'd3) begin
                    miscompares++;
                    $display("FAIL credit_addr k=%0d got=%0d exp=3", k, rd_addr);
                end
            end
            if (k >= 2) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== 4'd0 || m_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL credit_hold k=%0d valid=%b data=%0d last=%b exp 1 0 0", k, m_valid, m_data, m_last);
                end
            end
        end
        drain(8'hFF, 40);
        vectors++;
        if (cap.size() != 8 || last_idx != 7 || got_done !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_drain beats=%0d last_idx=%0d done=%b exp 8 7 1", cap.size(), last_idx, got_done);
        end
        for (int i = 0; i < cap.size(); i++) begin
            vectors++;
            if (cap[i] !== WIDTH'(i)) begin
                miscompares++;
                $display("FAIL credit_beat%0d got=%0d exp=%0d", i, cap[i], i);
            end
        end
        cyc();
    endtask

    task automatic test_len_edges();
        base_addr = 3'd3; len = 4'd0; m_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_done done=%b busy=%b valid=%b exp 1 0 0", done, busy, m_valid);
        end
        cyc();
        vectors++;
        if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_after done=%b valid=%b busy=%b exp 0 0 0", done, m_valid, busy);
        end
        base_addr = 3'd0; len = 4'd15; start = 1'b1;
        cyc();
        start = 1'b0;
        drain(8'hFF, 40);
        vectors++;
        if (cap.size() != 8 || last_idx != 7 || got_done !== 1'b1) begin
            miscompares++;
            $display("FAIL len15_sat beats=%0d last_idx=%0d done=%b exp 8 7 1", cap.size(), last_idx, got_done);
        end
        for (int i = 0; i < cap.size(); i++) begin
            vectors++;
            if (cap[i] !== WIDTH'(i)) begin
                miscompares++;
                $display("FAIL len15_beat%0d got=%0d exp=%0d", i, cap[i], i);
            end
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        base_addr = 3'd2; len = 4'd8; m_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        vectors++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_state valid=%b busy=%b done=%b exp 0 0 0", m_valid, busy, done);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (m_valid !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL rstmid_quiet got=activity exp=none");
        end
        base_addr = 3'd0; len = 4'd2; start = 1'b1;
        cyc();
        start = 1'b0;
        drain(8'hFF, 20);
        vectors++;
        if (cap.size() != 2 || got_done !== 1'b1 || last_idx != 1) begin
            miscompares++;
            $display("FAIL rstmid_fresh beats=%0d done=%b last_idx=%0d exp 2 1 1", cap.size(), got_done, last_idx);
        end else begin
            vectors++;
            if (cap[0] !== 4'd0 || cap[1] !== 4'd1) begin
                miscompares++;
                $display("FAIL rstmid_data got=%0d,%0d exp=0,1", cap[0], cap[1]);
            end
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic             ev, el, ed;
        logic [WIDTH-1:0] edat;
        base_addr = 3'd1; len = 4'd3; m_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            ev   = (k >= 2 && k <= 4) || k == 8 || k == 9;
            el   = (k == 4) || (k == 9);
            ed   = (k == 5) || (k == 10);
            edat = (k <= 4) ? WIDTH'(k - 1) : WIDTH'(k - 4);
            vectors++;
            if (m_valid !== ev || done !== ed || (ev && (m_data !== edat || m_last !== el))) begin
                miscompares++;
                $display("FAIL b2b_k%0d valid=%b done=%b data=%0d last=%b exp %b %b %0d %b",
                         k, m_valid, done, m_data, m_last, ev, ed, edat, el);
            end
            if (k == 6) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_accept busy=%b exp=1", busy);
                end
            end
            start = 1'b0;
            if (k == 1) begin
                start = 1'b1; base_addr = 3'd5; len = 4'd2;
            end
            if (k == 5) begin
                start = 1'b1; base_addr = 3'd4; len = 4'd2;
            end
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_credit();
        test_len_edges();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
